// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed valid/ready output stream for fifo_rd_packer.
// master = packer side, slave = FIFO/sink/environment side.
interface fifo_rd_packer_if #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
);
  localparam int LANE_W = $clog2(RATIO) + 1;

  logic                     fifo_empty;
  logic                     fifo_rd_en;
  logic [WIDTH-1:0]         fifo_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*RATIO-1:0]   out_data;
  logic [LANE_W-1:0]        out_lanes;

  modport master (
    input  fifo_empty, fifo_data, flush, out_ready,
    output fifo_rd_en, out_valid, out_data, out_lanes
  );

  modport slave (
    output fifo_empty, fifo_data, flush, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_lanes
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains a 1-cycle-latency FIFO and packs RATIO words into one valid/ready beat; flush emits a partial word.
// Optional macro PACKER_MSB_FIRST_EN: first captured word lands in the top lane, later words descend.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_rd_packer_if.master  bus
);
  localparam int LANE_W = $clog2(RATIO) + 1;
  localparam int DW     = WIDTH * RATIO;
  localparam logic [LANE_W-1:0] FULL = LANE_W'(RATIO);

  typedef enum logic {S_FILL, S_OUT} state_t;

  state_t              r_state,     w_state_nxt;
  logic [LANE_W-1:0]   r_cnt,       w_cnt_nxt;
  logic                r_pend;
  logic                r_flush_req, w_flush_req_nxt;
  logic                r_flushed,   w_flushed_nxt;
  logic                r_valid,     w_valid_nxt;
  logic [DW-1:0]       r_data,      w_data_nxt;
  logic [LANE_W-1:0]   r_lanes,     w_lanes_nxt;

  logic                w_rd_en;
  logic                w_hs;
  logic [LANE_W:0]     w_inflight;
  logic [LANE_W-1:0]   w_lane;

  // Words already held plus the one still in flight bound the next read.
  assign w_inflight = {1'b0, r_cnt} + {{LANE_W{1'b0}}, r_pend};
  assign w_rd_en    = rst && (r_state == S_FILL) && !bus.fifo_empty && !r_flush_req
                      && (w_inflight < {1'b0, FULL});
  assign w_hs       = r_valid && bus.out_ready;

`ifdef PACKER_MSB_FIRST_EN
  assign w_lane = FULL - LANE_W'(1) - r_cnt;
`else
  assign w_lane = r_cnt;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_flush_req_nxt = r_flush_req | bus.flush;
    w_flushed_nxt   = r_flushed;
    w_valid_nxt     = r_valid;
    w_data_nxt      = r_data;
    w_lanes_nxt     = r_lanes;
    case (r_state)
      S_FILL: begin
        // A pending capture always lands before a flush is honoured.
        if (r_pend) begin
          w_data_nxt[int'(w_lane)*WIDTH +: WIDTH] = bus.fifo_data;
          w_cnt_nxt = r_cnt + LANE_W'(1);
          if (r_cnt == FULL - LANE_W'(1)) begin
            w_state_nxt   = S_OUT;
            w_valid_nxt   = 1'b1;
            w_lanes_nxt   = FULL;
            w_flushed_nxt = 1'b0;
          end
        end else if (r_flush_req) begin
          if (r_cnt != '0) begin
            w_state_nxt   = S_OUT;
            w_valid_nxt   = 1'b1;
            w_lanes_nxt   = r_cnt;
            w_flushed_nxt = 1'b1;
          end else begin
            w_flush_req_nxt = 1'b0;
          end
        end
      end
      S_OUT: begin
        if (w_hs) begin
          w_state_nxt   = S_FILL;
          w_valid_nxt   = 1'b0;
          w_cnt_nxt     = '0;
          w_data_nxt    = '0;
          w_lanes_nxt   = '0;
          w_flushed_nxt = 1'b0;
          if (r_flushed) w_flush_req_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FILL;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_flush_req <= 1'b0;
      r_flushed   <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_lanes     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend      <= w_rd_en;
      r_flush_req <= w_flush_req_nxt;
      r_flushed   <= w_flushed_nxt;
      r_valid     <= w_valid_nxt;
      r_data      <= w_data_nxt;
      r_lanes     <= w_lanes_nxt;
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_valid  = r_valid;
  assign bus.out_data   = r_data;
  assign bus.out_lanes  = r_lanes;
endmodule
